// File: rtl/aes_cell_pkg.sv
// Shared types and sizing helpers for the pipelined lane OR-reduction.
// Stage widths shrink by FAN_IN per level until one bit remains.
package aes_cell_pkg;

    typedef enum logic [1:0] {
        RED_OR   = 2'd0,
        RED_NOR  = 2'd1,
        RED_AND  = 2'd2,
        RED_NAND = 2'd3
    } red_mode_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int stage_bits(input int lw, input int fi, input int s);
        int w;
        w = lw;
        for (int i = 0; i < s; i++) begin
            w = ceil_div(w, fi);
        end
        return w;
    endfunction

    function automatic int calc_lat(input int lw, input int fi);
        int w;
        int n;
        w = lw;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (w > 1) begin
                w = ceil_div(w, fi);
                n++;
            end
        end
        return (n == 0) ? 1 : n;
    endfunction

    // Offset of stage s input inside a per-lane packed chain bus.
    function automatic int bus_off(input int lw, input int fi, input int s);
        int o;
        o = 0;
        for (int j = 0; j < s; j++) begin
            o += stage_bits(lw, fi, j);
        end
        return o;
    endfunction

    function automatic logic inv_in(input logic [1:0] m);
        return (m == RED_AND) || (m == RED_NAND);
    endfunction

    function automatic logic inv_out(input logic [1:0] m);
        return (m == RED_NOR) || (m == RED_AND);
    endfunction

endpackage

// File: rtl/or_tree_stage.sv
// One registered level of an OR tree: groups of FAN_IN bits collapse
// to one bit each; unused group inputs are padded with zero.
module or_tree_stage #(
    parameter  int IN_BITS  = 4,
    parameter  int FAN_IN   = 4,
    localparam int OUT_BITS = (IN_BITS + FAN_IN - 1) / FAN_IN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                valid_i,
    input  logic [IN_BITS-1:0]  data_i,
    output logic                valid_o,
    output logic [OUT_BITS-1:0] data_o
);

    localparam int PAD_BITS = OUT_BITS * FAN_IN;

    logic [PAD_BITS-1:0] pad;
    logic [OUT_BITS-1:0] data_d;
    logic [OUT_BITS-1:0] data_q;
    logic                valid_q;

    always_comb begin
        pad = '0;
        pad[IN_BITS-1:0] = data_i;
        data_d = '0;
        for (int o = 0; o < OUT_BITS; o++) begin
            data_d[o] = |pad[o*FAN_IN +: FAN_IN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/or_reduce_pipe.sv
// Per-lane pipelined OR/NOR/AND/NAND reduction with a global stall
// and a sticky accumulator over delivered results.
import aes_cell_pkg::*;

module or_reduce_pipe #(
    parameter int WIDTH  = 128,
    parameter int LANES  = 4,
    parameter int FAN_IN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_red,
    input  logic             acc_clr,
    output logic [LANES-1:0] acc_out
);

    localparam int LW    = WIDTH / LANES;
    localparam int LAT   = calc_lat(LW, FAN_IN);
    localparam int BUS_W = bus_off(LW, FAN_IN, LAT + 1);

    logic             en;
    logic             hs;
    logic [LW-1:0]    inv_mask;
    logic [LANES-1:0] tree_q;
    logic [LANES-1:0] lane_vld;
    logic [1:0]       mode_q [LAT];
    logic [LANES-1:0] acc_d;
    logic [LANES-1:0] acc_q;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign hs       = out_valid && out_ready;
    // AND-type modes reduce the inverted bits, so 0 padding stays neutral.
    assign inv_mask = {LW{inv_in(in_mode)}};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BUS_W-1:0] bus;
        logic [LAT:0]     vld;

        assign bus[LW-1:0] = in_data[k*LW +: LW] ^ inv_mask;
        assign vld[0]      = in_valid;

        for (genvar s = 0; s < LAT; s++) begin : g_st
            localparam int IW = stage_bits(LW, FAN_IN, s);
            localparam int OW = stage_bits(LW, FAN_IN, s + 1);
            localparam int IO = bus_off(LW, FAN_IN, s);
            localparam int OO = bus_off(LW, FAN_IN, s + 1);

            or_tree_stage #(
                .IN_BITS (IW),
                .FAN_IN  (FAN_IN)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .valid_i (vld[s]),
                .data_i  (bus[IO +: IW]),
                .valid_o (vld[s+1]),
                .data_o  (bus[OO +: OW])
            );
        end

        assign tree_q[k]   = bus[BUS_W-1];
        assign lane_vld[k] = vld[LAT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                mode_q[i] <= RED_OR;
            end
        end else if (en) begin
            mode_q[0] <= in_mode;
            for (int i = 1; i < LAT; i++) begin
                mode_q[i] <= mode_q[i-1];
            end
        end
    end

    assign out_valid = &lane_vld;
    assign out_red   = tree_q ^ {LANES{inv_out(mode_q[LAT-1])}};

    always_comb begin
        acc_d = acc_q;
        if (hs) begin
            acc_d = (acc_clr ? '0 : acc_q) | out_red;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_out = acc_q;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Directed bench for or_reduce_pipe with default parameters (LAT = 3).
module tb_or_reduce_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_red;
    logic         acc_clr;
    logic [3:0]   acc_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] ZERO  = 128'h0;
    localparam logic [127:0] LANE0 = 128'h1;
    localparam logic [127:0] LANE1 = 128'h1 << 32;
    localparam logic [127:0] LANE2 = 128'h0000_8000 << 64;
    localparam logic [127:0] LANE3 = 128'h1 << 96;
    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] FE    =
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;

    or_reduce_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_red   (out_red),
        .acc_clr   (acc_clr),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    // Two beats back to back, results expected in cycles 3 and 4.
    task automatic pipe2(input string tag,
                         input logic [127:0] da, input logic [1:0] ma,
                         input logic [3:0] ea,
                         input logic [127:0] db, input logic [1:0] mb,
                         input logic [3:0] eb);
        cyc(); in_valid = 1; in_data = da; in_mode = ma;
        cyc(); in_data = db; in_mode = mb;
        cyc(); in_valid = 0;
        cyc(); smp();
        chk({tag, "_a_vld"}, out_valid, 1);
        chk({tag, "_a_red"}, out_red, ea);
        cyc(); smp();
        chk({tag, "_b_vld"}, out_valid, 1);
        chk({tag, "_b_red"}, out_red, eb);
        cyc(); smp();
        chk({tag, "_idle"}, out_valid, 0);
    endtask

    logic [127:0] bd [5];
    logic [1:0]   bm [5];
    logic [3:0]   be [5];
    int sent;
    int got;

    initial begin
        rst = 1; in_valid = 0; in_data = '0; in_mode = 0;
        out_ready = 1; acc_clr = 0;
        cyc(); cyc(); smp();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_red", out_red, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_in_ready", in_ready, 1);

        // single zero beat, OR mode
        cyc(); rst = 0; in_valid = 1; in_data = ZERO; in_mode = 0;
        cyc(); in_valid = 0; smp();
        chk("lat_c1", out_valid, 0);
        cyc(); smp();
        chk("lat_c2", out_valid, 0);
        cyc(); smp();
        chk("lat_c3", out_valid, 1);
        chk("zero_or", out_red, 4'b0000);

        pipe2("lane2", LANE2, 2'd0, 4'b0100, LANE2, 2'd1, 4'b1011);
        pipe2("andn", FE, 2'd2, 4'b1110, FE, 2'd3, 4'b0001);
        chk("acc_sticky", acc_out, 4'b1111);

        cyc(); acc_clr = 1;
        cyc(); acc_clr = 0; smp();
        chk("acc_clr_alone", acc_out, 4'b0000);

        pipe2("acc", FE, 2'd3, 4'b0001, LANE2, 2'd0, 4'b0100);
        chk("acc_0101", acc_out, 4'b0101);

        cyc(); in_valid = 1; in_data = LANE3; in_mode = 0;
        cyc(); in_valid = 0;
        cyc();
        cyc(); acc_clr = 1; smp();
        chk("clr_hs_vld", out_valid, 1);
        chk("clr_hs_red", out_red, 4'b1000);
        cyc(); acc_clr = 0; smp();
        chk("acc_clr_hs", acc_out, 4'b1000);

        // five beats with out_ready low in cycles 4-6
        bd[0] = LANE0; bm[0] = 2'd0; be[0] = 4'b0001;
        bd[1] = LANE1; bm[1] = 2'd1; be[1] = 4'b1101;
        bd[2] = ONES;  bm[2] = 2'd2; be[2] = 4'b1111;
        bd[3] = LANE3; bm[3] = 2'd1; be[3] = 4'b0111;
        bd[4] = LANE2; bm[4] = 2'd0; be[4] = 4'b0100;
        sent = 0;
        got = 0;
        for (int c = 0; c < 16; c++) begin
            cyc();
            in_valid = (sent < 5);
            in_data = (sent < 5) ? bd[sent] : ZERO;
            in_mode = (sent < 5) ? bm[sent] : 2'd0;
            out_ready = !(c >= 4 && c <= 6);
            smp();
            if (c <= 10) begin
                chk($sformatf("in_ready_c%0d", c), in_ready,
                    (c >= 4 && c <= 6) ? 1'b0 : 1'b1);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                if (got < 5) begin
                    chk($sformatf("stream_c%0d", c), out_red, be[got]);
                    if (out_ready) got++;
                end else begin
                    chk($sformatf("extra_c%0d", c), out_valid, 0);
                end
            end
        end
        in_valid = 0;
        out_ready = 1;
        chk("stream_sent", sent, 5);
        chk("stream_got", got, 5);

        // reset with two beats in flight
        cyc(); in_valid = 1; in_data = ZERO; in_mode = 1;
        cyc(); in_data = LANE0; in_mode = 0;
        cyc(); rst = 1; acc_clr = 1;
        cyc(); rst = 0; acc_clr = 0; in_valid = 0; smp();
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_acc", acc_out, 0);
        chk("rst2_out_red", out_red, 0);
        chk("rst2_in_ready", in_ready, 1);
        for (int c = 0; c < 6; c++) begin
            cyc(); smp();
            chk($sformatf("no_stale_c%0d", c), out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/or_reduce_pipe.md
OR_REDUCE_PIPE -- requirements
Module: or_reduce_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 128, total data bits reduced per beat.
REQ-002 SHALL have parameter LANES, default 4, independent reduction lanes; WIDTH % LANES == 0; lane width LW = WIDTH/LANES.
REQ-003 SHALL have parameter FAN_IN, default 4, OR inputs per tree node per stage (2..8).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_data/in_mode valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  data; lane k = bits [k*LW +: LW].
REQ-009 SHALL have port in_mode  input  2  per-beat mode: 0 OR, 1 NOR, 2 AND, 3 NAND.
REQ-010 SHALL have port out_valid  output  1  out_red holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out_red  output  LANES  per-lane reduction result.
REQ-013 SHALL have port acc_clr  input  1  clear sticky accumulator.
REQ-014 SHALL have port acc_out  output  LANES  sticky OR of all delivered out_red since last clear.

Function
REQ-015 SHALL reduce each lane through LAT = ceil(log_FAN_IN(LW)) register stages (LW=1 -> LAT=1, single register); WIDTH=128/LANES=4/FAN_IN=4 -> LAT=3.
REQ-016 SHALL perform AND modes as OR of inverted lane bits with inverted final result; NAND/NOR invert final result; mode travels alongside data through the pipe.
REQ-017 SHALL pad unused node inputs with 0 (OR-neutral after any inversion).
REQ-018 SHALL carry one valid bit per stage; a beat accepted at edge N appears with out_valid at edge N+LAT when unstalled.
REQ-019 SHALL stall the whole pipe (all stages hold) when out_valid=1 and out_ready=0; in_ready = !(out_valid && !out_ready).
REQ-020 SHALL advance empty bubbles while stalled? No: stall is global; bubbles are not compressed.
REQ-021 SHALL accept a beat only when in_valid && in_ready; no data loss or duplication under any valid/ready pattern.
REQ-022 SHALL update acc_out on each output handshake (out_valid && out_ready): acc_out <= acc_out | out_red.
REQ-023 SHALL, when acc_clr and an output handshake coincide, load acc_out <= out_red (clear then include that beat); acc_clr alone -> acc_out <= 0.
REQ-024 SHALL hold out_red stable while out_valid=1 and out_ready=0.

Reset
REQ-025 SHALL on rst clear all stage valid bits, out_valid=0, out_red=0, acc_out=0, in_ready=1 next cycle.
REQ-026 SHALL let rst override acc_clr, in_valid and handshakes in the same cycle; in-flight beats are discarded.
REQ-027 SHALL not require data-path stage registers to be reset other than out_red.

Structure
REQ-028 SHALL place mode enum (RED_OR, RED_NOR, RED_AND, RED_NAND) and a constant function computing LAT in shared package aes_cell_pkg.
REQ-029 SHALL instantiate one sub-module or_tree_stage (parameters IN_BITS, FAN_IN; one registered level with enable and valid) LAT times per lane via generate.
REQ-030 SHALL contain no latches, no combinational path from in_* to out_*; out_ready -> in_ready is the only combinational path.

Verification
REQ-031 SHALL cover: defaults, in_data=0, mode OR, one beat -> out_valid at cycle 3, out_red=4'b0000.
REQ-032 SHALL cover: in_data lane2 = 32'h0000_8000 else 0, mode OR then NOR -> out_red 4'b0100 then 4'b1011.
REQ-033 SHALL cover: in_data=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, mode AND -> 4'b1110; NAND -> 4'b0001.
REQ-034 SHALL cover: back-to-back 5 beats, out_ready low cycles 4-6 -> in_ready low same cycles, all 5 results delivered in order, none duplicated.
REQ-035 SHALL cover: results 4'b0001,4'b0100 delivered -> acc_out=4'b0101; acc_clr with next result 4'b1000 -> acc_out=4'b1000.
REQ-036 SHALL cover: rst asserted with 2 beats in flight -> out_valid=0, acc_out=0 next cycle, no stale result emerges afterwards.
